// File: rtl/lab8_soc_frame_pkg.sv
// Shared types and constants for the lab8_soc frame-clock poller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lab8_soc_frame_pkg;

    // Poller FSM: wait for tick, present read, wait out slave latency, capture
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        LAT     = 2'd2,
        CAPTURE = 2'd3
    } poll_state_e;

    // Word address of the PIO data register on its s1 port
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    // Width of the change-event counter; wraps naturally
    localparam int CHANGE_CNT_W = 16;

endpackage

// File: rtl/lab8_soc_poll_timer.sv
// Free-running reloadable down-counter that raises a one-cycle tick every POLL_PERIOD enabled cycles.
// Latency: first tick in the POLL_PERIOD-th enabled cycle (cycle POLL_PERIOD-1 counting from 0).
// Backpressure: none; ticks are never held or queued, the consumer must take them or drop them.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-high reset, loads POLL_PERIOD-1
//   enable - count while high; while low the counter is parked at POLL_PERIOD-1
//   tick   - one-cycle pulse in the cycle the counter reads 0 with enable high
module lab8_soc_poll_timer #(
    parameter int POLL_PERIOD = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int              CNT_W  = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (!enable) begin
            // Parking at the reload value makes the first tick after enable
            // rises land exactly POLL_PERIOD-1 cycles later.
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lab8_soc_frame_poller.sv
// Avalon-MM master that periodically reads the frame-clock PIO data register and flags value changes.
// Latency: read issued the cycle after a tick; capture visible READ_LATENCY+1 cycles after acceptance.
// Backpressure: avm_read held while avm_waitrequest=1; ticks arriving while busy are dropped and set overrun.
//
// Ports:
//   clk, reset       - system clock, asynchronous active-high reset
//   enable           - polling enable (an in-flight read always completes)
//   avm_address      - constant PIO data register address
//   avm_read         - registered read request
//   avm_waitrequest  - slave stall
//   avm_readdata     - slave read data; only [DATA_W-1:0] is used
//   value            - last captured value
//   value_valid      - set by the first capture after reset
//   change_pulse     - one-cycle pulse when a capture differs from the previous value
//   change_count     - number of change pulses, wraps
//   overrun          - sticky: a tick arrived while a read was outstanding
//   busy             - FSM is not IDLE
module lab8_soc_frame_poller
    import lab8_soc_frame_pkg::*;
#(
    parameter int POLL_PERIOD  = 1000,
    parameter int READ_LATENCY = 1,
    parameter int DATA_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic [1:0]              avm_address,
    output logic                    avm_read,
    input  logic                    avm_waitrequest,
    input  logic [31:0]             avm_readdata,
    output logic [DATA_W-1:0]       value,
    output logic                    value_valid,
    output logic                    change_pulse,
    output logic [CHANGE_CNT_W-1:0] change_count,
    output logic                    overrun,
    output logic                    busy
);

    // LAT counts 0..READ_LATENCY-2; sized so READ_LATENCY=1 still has a legal width
    localparam int               LAT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0);

    logic tick;

    poll_state_e             state_q,   state_d;
    logic                    read_q,    read_d;
    logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0]       value_q,   value_d;
    logic                    valid_q,   valid_d;
    logic                    pulse_q,   pulse_d;
    logic [CHANGE_CNT_W-1:0] count_q,   count_d;
    logic                    overrun_q, overrun_d;

    logic [DATA_W-1:0] rd_low;
    logic              unused_rd_bits;

    assign rd_low         = avm_readdata[DATA_W-1:0];
    assign unused_rd_bits = ^avm_readdata[31:DATA_W];

    lab8_soc_poll_timer #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        value_d   = value_q;
        valid_d   = valid_q;
        pulse_d   = 1'b0;
        count_d   = count_q;
        // A tick can only be honoured from IDLE; anywhere else it is lost.
        overrun_d = overrun_q | (tick && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // enable is deliberately ignored here: a presented read cannot be withdrawn.
                if (!avm_waitrequest) begin
                    if (READ_LATENCY > 1) begin
                        state_d   = LAT;
                        lat_cnt_d = '0;
                    end else begin
                        state_d = CAPTURE;
                    end
                end
            end
            LAT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            CAPTURE: begin
                value_d = rd_low;
                valid_d = 1'b1;
                // The very first capture has nothing meaningful to compare against.
                if (valid_q && (rd_low != value_q)) begin
                    pulse_d = 1'b1;
                    count_d = count_q + CHANGE_CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered request: high for exactly the cycles spent in REQ.
        read_d = (state_d == REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            read_q    <= 1'b0;
            lat_cnt_q <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            pulse_q   <= 1'b0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            lat_cnt_q <= lat_cnt_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            pulse_q   <= pulse_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign avm_address  = PIO_DATA_ADDR;
    assign avm_read     = read_q;
    assign value        = value_q;
    assign value_valid  = valid_q;
    assign change_pulse = pulse_q;
    assign change_count = count_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: doc/lab8_soc_frame_poller.md
# lab8_soc_frame_poller

Avalon-MM master that periodically reads the 8-bit frame-clock PIO data register, so frame activity is tracked in hardware without CPU polling. It issues one single-word read every POLL_PERIOD cycles and captures the low 8 bits of the returned word. It flags value changes with a one-cycle pulse and a change counter for downstream game logic. It sits in lab8_soc beside the PIO and drives that PIO's s1 slave port.

## Interface

- POLL_PERIOD, 1000: cycles between poll ticks; legal range ≥ READ_LATENCY+4.
- READ_LATENCY, 1: fixed slave read latency in cycles; the PIO registers readdata, so 1.
- DATA_W, 8: captured width; it is the low bits of avm_readdata.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  polling enable.
- avm_address  out  2  constant 2'd0 (PIO data register).
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall; tie 0 for the PIO.
- avm_readdata  in  32  slave read data.
- value  out  DATA_W  last captured value.
- value_valid  out  1  high once the first capture completes.
- change_pulse  out  1  one-cycle pulse when a capture differs from the previous value.
- change_count  out  16  number of change_pulse events; wraps at 16 bits.
- overrun  out  1  sticky: a tick arrived while a read was still outstanding.
- busy  out  1  a read is in flight (state ≠ IDLE).

## Operation

- Reset values:
  - avm_read=0, avm_address=0.
  - value=0, value_valid=0, change_pulse=0, change_count=0.
  - overrun=0, busy=0.
  - Timer = POLL_PERIOD-1; state = IDLE.
- Timer:
  - Decrements every cycle while enable=1.
  - At 0 it raises a one-cycle tick and reloads POLL_PERIOD-1.
  - While enable=0, the timer holds at POLL_PERIOD-1 and no tick is generated.
- FSM states: IDLE, REQ, LAT, CAPTURE.
  - IDLE → REQ on tick. avm_read is registered and goes high on entry to REQ.
  - REQ: hold avm_read=1 and the address stable while avm_waitrequest=1. The acceptance cycle is avm_read=1 and avm_waitrequest=0; the next state is LAT and avm_read drops.
  - LAT: count READ_LATENCY-1 cycles. When READ_LATENCY=1, LAT lasts zero cycles and avm_readdata is sampled on the edge ending the acceptance cycle's successor.
  - CAPTURE: set value ← avm_readdata[DATA_W-1:0].
    - If value_valid was 1 and the new data differs from value: change_pulse=1 for one cycle and change_count+1.
    - The first capture after reset sets value_valid and never pulses.
    - Next state is IDLE.
- Tick while state ≠ IDLE: set overrun=1 and drop the tick. No queueing.
- enable falling mid-transaction: the current read completes and captures normally, because Avalon forbids withdrawing a stalled read.
- Upper bits avm_readdata[31:DATA_W] are ignored.
- Reset asserted mid-read: all state returns to reset values immediately and avm_read=0 asynchronously. The slave's pending response is ignored.

## Timing

- Cycle 0 is the first cycle with enable=1 after reset.
- Tick in cycle POLL_PERIOD-1; avm_read high in cycle POLL_PERIOD.
- With waitrequest=0, the read is accepted in cycle POLL_PERIOD.
  - Data is sampled READ_LATENCY cycles later.
  - value, change_pulse and change_count update on that edge and are visible in cycle POLL_PERIOD+READ_LATENCY+1.
- Each waitrequest stall cycle delays all of the above by one cycle but does not shift the timer.
- Steady-state reads are exactly POLL_PERIOD cycles apart, measured tick to tick.

## Structure

- Package lab8_soc_frame_pkg holds:
  - the state enum (IDLE, REQ, LAT, CAPTURE);
  - PIO_DATA_ADDR = 2'd0;
  - CHANGE_CNT_W = 16.
- Sub-module lab8_soc_poll_timer(POLL_PERIOD) contains the reloadable down-counter. Its ports are clk, reset and enable; its output is tick.
- The FSM, capture register and counters live in the top module.

## Test plan

- POLL_PERIOD=8, waitrequest=0, readdata=0x0000_00A5, enable from cycle 0:
  - avm_read high exactly in cycles 8, 16, 24.
  - value=0xA5 and value_valid=1 from cycle 10.
  - change_pulse never asserts.
- Readdata changes 0xA5→0x3C before the second poll: change_pulse high for exactly one cycle (cycle 18); change_count=1.
- waitrequest held high for 3 cycles on the first read:
  - avm_read stays high in cycles 8–11 with avm_address=0.
  - Capture is visible in cycle 13.
  - The next read still starts in cycle 16.
- waitrequest held high for 10 cycles: the tick at cycle 15 sets overrun=1; no second read is issued until the next tick after IDLE is reached.
- readdata=0xFFFF_FF00 versus 0x0000_0000: no change pulse, because only bits [7:0] are compared.
- Reset asserted while avm_read is high under stall: avm_read drops immediately; all outputs return to reset values; polling restarts POLL_PERIOD cycles after release with enable=1.
